// File: rtl/adc_spi_responder.sv
// Serial ADC emulator: on an adconv strobe it latches two channel samples and
// shifts them out on miso, one slot per sck falling edge, framed by idle gaps.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   adconv, sck         : asynchronous strobes from the SPI master
//   sample_a, sample_b  : DATA_W-bit channel values
//   miso                : serial data to the master
//   busy, frame_done    : frame status, one-cycle frame end pulse
//   overrun             : one-cycle pulse on adconv while a frame is active
module adc_spi_responder #(
  parameter int DATA_W   = 14,
  parameter int GAP_BITS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              adconv,
  input  logic              sck,
  input  logic [DATA_W-1:0] sample_a,
  input  logic [DATA_W-1:0] sample_b,
  output logic              miso,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int FRAME = 3*GAP_BITS + 2*DATA_W;
  localparam int KW    = $clog2(FRAME + 1);
  localparam int SW    = 2*DATA_W;

  localparam logic [KW-1:0] A_LO = KW'(GAP_BITS + 1);
  localparam logic [KW-1:0] A_HI = KW'(GAP_BITS + DATA_W);
  localparam logic [KW-1:0] B_LO = KW'(2*GAP_BITS + DATA_W + 1);
  localparam logic [KW-1:0] B_HI = KW'(2*GAP_BITS + 2*DATA_W);
  localparam logic [KW-1:0] LAST = KW'(FRAME);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k, k_nx, kn;
  logic [SW-1:0] sh, sh_nx;
  logic          miso_nx, busy_nx, done_nx, ovr_nx;

  // [0] first sync flop, [1] second sync flop, [2] previous synced value
  logic [2:0] adc_sr, sck_sr;
  logic       adc_rise, sck_fall;
  logic       in_a, in_b;

  assign adc_rise = adc_sr[1] & ~adc_sr[2];
  assign sck_fall = ~sck_sr[1] & sck_sr[2];

  // kn is the slot number this falling edge will register
  assign kn   = k + KW'(1);
  assign in_a = (kn >= A_LO) && (kn <= A_HI);
  assign in_b = (kn >= B_LO) && (kn <= B_HI);

  always_comb begin
    state_nx = state;
    k_nx     = k;
    sh_nx    = sh;
    miso_nx  = miso;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ovr_nx   = adc_rise && (state != IDLE);
    unique case (state)
      IDLE: begin
        miso_nx = 1'b0;
        if (adc_rise) begin
          sh_nx    = {sample_a, sample_b};
          k_nx     = '0;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_fall) begin
          k_nx = kn;
          if (kn == LAST) begin
            miso_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = DONE;
          end else if (in_a || in_b) begin
            miso_nx = sh[SW-1];
            sh_nx   = {sh[SW-2:0], 1'b0};
          end else begin
            miso_nx = 1'b0;
          end
        end
      end
      DONE: begin
        miso_nx  = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        miso_nx  = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      adc_sr     <= '0;
      sck_sr     <= '0;
      state      <= IDLE;
      k          <= '0;
      sh         <= '0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      adc_sr     <= {adc_sr[1], adc_sr[0], adconv};
      sck_sr     <= {sck_sr[1], sck_sr[0], sck};
      state      <= state_nx;
      k          <= k_nx;
      sh         <= sh_nx;
      miso       <= miso_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
      overrun    <= ovr_nx;
    end
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, giving bits per channel sample.
REQ-002 The block SHALL have parameter GAP_BITS, default 2, giving the idle sck slots before each channel and after the last channel.
REQ-003 The block SHALL have port clock, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port adconv, input, 1 bit, the conversion strobe from the SPI master; it is asynchronous to clock.
REQ-006 The block SHALL have port sck, input, 1 bit, the SPI serial clock from the master; it is asynchronous to clock.
REQ-007 The block SHALL have port sample_a, input, DATA_W bits, the channel A two's-complement value to transmit.
REQ-008 The block SHALL have port sample_b, input, DATA_W bits, the channel B two's-complement value to transmit.
REQ-009 The block SHALL have port miso, output, 1 bit, the serial data to the master.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-011 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at frame end.
REQ-012 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when adconv rises while busy.

Function
REQ-013 adconv and sck SHALL each pass through a 2-flop synchronizer; a third register SHALL hold the previous synchronized value for edge detection.
REQ-014 A rising edge SHALL be detected when prev=0 and sync=1; a falling edge when prev=1 and sync=0.
REQ-015 The state machine SHALL have three states: IDLE, SHIFT, DONE.
REQ-016 IDLE to SHIFT: on an adconv rising edge, sample_a and sample_b SHALL be latched into a 2*DATA_W shift register, the falling-edge counter k SHALL be cleared to 0, and busy SHALL be set.
REQ-017 In SHIFT, each sck falling edge SHALL increment k; with the default parameters the frame is 34 slots.
REQ-018 On the k-th falling edge, miso SHALL be registered as follows.
- k = 1..GAP_BITS: 0.
- Next DATA_W slots: A[DATA_W-1] down to A[0], MSB first.
- Next GAP_BITS slots: 0.
- Next DATA_W slots: B[DATA_W-1] down to B[0].
- Final GAP_BITS slots: 0.
REQ-019 miso SHALL change exactly on the clock edge that registers the falling-edge detection, i.e. the 3rd rising clock edge after sck is first sampled low; sck rising edges SHALL NOT change miso.
REQ-020 On the final falling edge (k = 3*GAP_BITS + 2*DATA_W), the block SHALL drive miso=0 and go to DONE.
REQ-021 DONE SHALL assert frame_done for exactly one cycle, clear busy, and return to IDLE on the next clock.
REQ-022 An adconv rising edge in SHIFT or DONE SHALL pulse overrun for one cycle and SHALL NOT alter the latched data, k, or the frame.
REQ-023 If an adconv rising edge coincides with the final falling edge, frame completion SHALL take precedence, overrun SHALL pulse, and no new frame SHALL start.
REQ-024 sck edges in IDLE SHALL be ignored, and miso SHALL be held at 0 in IDLE.
REQ-025 If adconv rises and the sck falling edge is detected in the same cycle while in IDLE, the frame SHALL start and that sck edge SHALL NOT be counted.
REQ-026 sample_a and sample_b changes after the latch SHALL NOT affect the frame in progress.

Reset
REQ-027 While reset is high, on each clock edge the block SHALL set state=IDLE, k=0, shift register=0, miso=0, busy=0, frame_done=0, overrun=0, and all synchronizer/edge registers=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no frame_done; the first adconv rising edge after reset deasserts SHALL start a fresh frame.

Verification
REQ-029 Scenario: sample_a=14'h2ABC, sample_b=14'h1234, 100 MHz clock, adconv pulse, then 34 sck cycles at 10 MHz -> the master, sampling on sck rising edges, captures 00, 10101010111100, 00, 01001000110100, 00; frame_done pulses once after the 34th fall.
REQ-030 Scenario: adconv pulses again after 10 sck cycles -> overrun pulses one cycle; the frame still carries 14'h2ABC / 14'h1234; exactly one frame_done.
REQ-031 Scenario: reset asserted after 20 sck falls -> miso=0 and busy=0 the next cycle; no frame_done; a following adconv with sample_a=14'h3FFF, sample_b=14'h0000 -> a full correct frame.
REQ-032 Scenario: 5 sck cycles with no adconv -> miso stays 0, busy stays 0.
REQ-033 Scenario: sample_a changed to 14'h0001 immediately after adconv -> the frame still carries the latched 14'h2ABC.
REQ-034 Scenario: two back-to-back frames with adconv one clock after frame_done -> both frames correct, no overrun.
